// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage-register states, per-boundary bundle widths and control-field positions.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY,
        PS_FULL,
        PS_SKID
    } ps_state_t;

    localparam int IF_ID_DATA_W  = 64;
    localparam int IF_ID_CTRL_W  = 14;
    localparam int ID_EX_DATA_W  = 176;
    localparam int ID_EX_CTRL_W  = 14;
    localparam int EX_MEM_DATA_W = 107;
    localparam int EX_MEM_CTRL_W = 14;
    localparam int MEM_WB_DATA_W = 71;
    localparam int MEM_WB_CTRL_W = 14;

    localparam int CB_REG_DST    = 0;
    localparam int CB_ALU_SRC    = 1;
    localparam int CB_MEM_TO_REG = 2;
    localparam int CB_REG_WRITE  = 3;
    localparam int CB_MEM_READ   = 4;
    localparam int CB_MEM_WRITE  = 5;
    localparam int CB_BRANCH     = 6;
    localparam int CB_JUMP       = 7;
    localparam int CB_ALU_OP     = 8;
    localparam int CB_ALU_OP_W   = 3;
    localparam int CB_TYPE       = 11;
    localparam int CB_TYPE_W     = 3;
    localparam int CTRL_BITS     = 14;

    // True when the control word would change architectural state downstream.
    function automatic logic ctrl_has_side_effect(input logic [CTRL_BITS-1:0] c);
        return c[CB_REG_WRITE] | c[CB_MEM_WRITE];
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// pipe_stage_slot: one stage entry (valid, data, ctrl); clear empties the entry and zeroes ctrl.
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = ID_EX_DATA_W,
    parameter int CTRL_W = ID_EX_CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= in_data;
            ctrl  <= in_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline boundary register with valid/ready, optional skid entry, flush and hit freeze.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = ID_EX_DATA_W,
    parameter int CTRL_W = ID_EX_CTRL_W,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hit,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              skid_full
);

    ps_state_t         state;
    logic              ti, to;
    logic              main_load, main_clear, skid_load, skid_clear;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data, main_src_data;
    logic [CTRL_W-1:0] skid_ctrl, main_src_ctrl;

    always_comb state = skid_valid ? PS_SKID : out_valid ? PS_FULL : PS_EMPTY;

    assign in_ready = SKID ? !skid_valid : (!out_valid | out_ready);
    assign ti       = in_valid & in_ready & hit;
    assign to       = out_valid & out_ready & hit;

    // Flush wins over every transfer; draining to EMPTY goes through clear so ctrl becomes a bubble.
    always_comb begin
        main_load  = !flush & (state == PS_EMPTY ? ti : state == PS_FULL ? (ti & to) : to);
        main_clear = flush | (state == PS_FULL & to & !ti);
        skid_load  = !flush & (state == PS_FULL) & ti & !to;
        skid_clear = flush | (state == PS_SKID & to);
    end

    assign main_src_data = state == PS_SKID ? skid_data : in_data;
    assign main_src_ctrl = state == PS_SKID ? skid_ctrl : in_ctrl;
    assign skid_full     = skid_valid;

    pipe_stage_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (main_load),
        .clear   (main_clear),
        .in_data (main_src_data),
        .in_ctrl (main_src_ctrl),
        .valid   (out_valid),
        .data    (out_data),
        .ctrl    (out_ctrl)
    );

    generate
        if (SKID) begin : g_skid
            pipe_stage_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (skid_load),
                .clear   (skid_clear),
                .in_data (in_data),
                .in_ctrl (in_ctrl),
                .valid   (skid_valid),
                .data    (skid_data),
                .ctrl    (skid_ctrl)
            );
        end else begin : g_no_skid
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
            assign skid_ctrl  = '0;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg in skid and single-register modes.
module tb_pipe_stage_reg;
    localparam int DW = 176;
    localparam int CW = 14;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    logic          clk = 1'b1;
    logic          rst_n = 1'b0;
    logic          hit = 1'b1, flush = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b1;
    logic          in_ready, out_valid, skid_full;
    logic [DW-1:0] in_data = '0, out_data;
    logic [CW-1:0] in_ctrl = '0, out_ctrl;
    logic          s0_in_valid = 1'b0, s0_out_ready = 1'b1;
    logic          s0_in_ready, s0_out_valid, s0_skid_full;
    logic [DW-1:0] s0_in_data = '0, s0_out_data;
    logic [CW-1:0] s0_in_ctrl = '0, s0_out_ctrl;

    int   n_checks = 0, n_fail = 0, n_out = 0;
    ent_t sb[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .hit(hit), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .skid_full(skid_full)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .hit(hit), .flush(flush),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data), .in_ctrl(s0_in_ctrl),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data), .out_ctrl(s0_out_ctrl),
        .skid_full(s0_skid_full)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int i);
        return (DW'(i) << 100) | DW'(32'(i) * 32'h9E37_79B9);
    endfunction

    function automatic logic [CW-1:0] mk_ctrl(input int i);
        return CW'(i * 37 + 1);
    endfunction

    // Active edge is negedge: the monitor sees the handshake at the preceding posedge.
    always @(posedge clk) begin
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready && hit) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("sb_underflow", DW'(sb.size()), DW'(1));
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    check("sb_data", out_data, e.d);
                    check("sb_ctrl", DW'(out_ctrl), DW'(e.c));
                end
            end
            if (in_valid && in_ready && hit)
                sb.push_back({in_data, in_ctrl});
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input int i);
        in_valid = v;
        in_data  = mk_data(i);
        in_ctrl  = mk_ctrl(i);
    endtask

    initial begin
        in_valid = 1'b1;
        in_ctrl  = 14'h3FFF;
        in_data  = mk_data(99);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("rst_out_valid", DW'(out_valid), DW'(0));
            check("rst_out_ctrl", DW'(out_ctrl), DW'(0));
            check("rst_out_data", out_data, DW'(0));
            check("rst_in_ready", DW'(in_ready), DW'(1));
            check("rst_skid_full", DW'(skid_full), DW'(0));
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;

        for (int i = 1; i <= 8; i++) begin
            offer(1'b1, i);
            tick();
            check("stream_valid", DW'(out_valid), DW'(1));
            check("stream_data", out_data, mk_data(i));
            check("stream_skid", DW'(skid_full), DW'(0));
        end
        offer(1'b0, 0);
        tick();
        check("stream_end_valid", DW'(out_valid), DW'(0));
        check("stream_bubble_ctrl", DW'(out_ctrl), DW'(0));

        out_ready = 1'b0;
        offer(1'b1, 20);
        tick();
        check("bp_a_main", out_data, mk_data(20));
        check("bp_a_ready", DW'(in_ready), DW'(1));
        offer(1'b1, 21);
        tick();
        check("bp_b_skid", DW'(skid_full), DW'(1));
        check("bp_b_ready", DW'(in_ready), DW'(0));
        check("bp_a_held", out_data, mk_data(20));
        offer(1'b0, 0);
        out_ready = 1'b1;
        tick();
        check("bp_b_main", out_data, mk_data(21));
        check("bp_b_ctrl", DW'(out_ctrl), DW'(mk_ctrl(21)));
        check("bp_ready_back", DW'(in_ready), DW'(1));
        check("bp_skid_drained", DW'(skid_full), DW'(0));
        tick();
        check("bp_empty", DW'(out_valid), DW'(0));

        offer(1'b1, 30);
        tick();
        hit = 1'b0;
        offer(1'b1, 31);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("frz_data", out_data, mk_data(30));
            check("frz_valid", DW'(out_valid), DW'(1));
            check("frz_skid", DW'(skid_full), DW'(0));
        end
        hit = 1'b1;
        tick();
        check("frz_resume", out_data, mk_data(31));
        offer(1'b0, 0);
        tick();
        check("frz_empty", DW'(out_valid), DW'(0));

        out_ready = 1'b0;
        offer(1'b1, 40);
        tick();
        offer(1'b1, 41);
        tick();
        check("fl_pre_skid", DW'(skid_full), DW'(1));
        offer(1'b1, 42);
        flush = 1'b1;
        hit   = 1'b0;
        tick();
        check("fl_valid", DW'(out_valid), DW'(0));
        check("fl_ctrl", DW'(out_ctrl), DW'(0));
        check("fl_skid", DW'(skid_full), DW'(0));
        check("fl_ready", DW'(in_ready), DW'(1));
        flush = 1'b0;
        hit   = 1'b1;
        out_ready = 1'b1;
        offer(1'b0, 0);
        tick();
        check("fl_dropped", DW'(out_valid), DW'(0));
        offer(1'b1, 43);
        tick();
        check("fl_after", out_data, mk_data(43));
        offer(1'b0, 0);
        tick();

        out_ready = 1'b0;
        offer(1'b1, 50);
        tick();
        offer(1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", DW'(out_valid), DW'(0));
        check("arst_data", out_data, DW'(0));
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;

        s0_in_valid = 1'b1;
        s0_in_data  = mk_data(60);
        s0_in_ctrl  = mk_ctrl(60);
        #1;
        check("s0_ready_empty", DW'(s0_in_ready), DW'(1));
        tick();
        check("s0_load", s0_out_data, mk_data(60));
        s0_out_ready = 1'b0;
        s0_in_data   = mk_data(61);
        s0_in_ctrl   = mk_ctrl(61);
        #1;
        check("s0_ready_low", DW'(s0_in_ready), DW'(0));
        tick();
        check("s0_held", s0_out_data, mk_data(60));
        s0_out_ready = 1'b1;
        #1;
        check("s0_ready_comb", DW'(s0_in_ready), DW'(1));
        tick();
        check("s0_replace", s0_out_data, mk_data(61));
        check("s0_replace_ctrl", DW'(s0_out_ctrl), DW'(mk_ctrl(61)));
        check("s0_no_skid", DW'(s0_skid_full), DW'(0));
        s0_in_valid = 1'b0;
        tick();
        check("s0_empty", DW'(s0_out_valid), DW'(0));
        check("s0_bubble", DW'(s0_out_ctrl), DW'(0));

        tick();
        check("sb_drained", DW'(sb.size()), DW'(0));
        check("sb_out_count", DW'(n_out), DW'(13));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed per-boundary registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries a data bundle plus a control bundle. It adds a valid/ready handshake, an optional one-entry skid buffer, a synchronous flush that inserts a bubble, and the global `hit` freeze used during cache misses. It sits between adjacent pipeline stages and is clocked on the falling edge of `clk`, like the rest of the pipeline.

## Interface
- `DATA_W`, 176: width of the data bundle (operands, immediate, PC values, register indices).
- `CTRL_W`, 14: width of the control bundle; this bundle is forced to zero whenever the stage holds no valid entry.
- `SKID`, 1: 1 adds a one-entry skid buffer with registered `in_ready`; 0 gives a single register with combinational `in_ready`.

- `clk`  in  1  pipeline clock; all state updates on the falling edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hit`  in  1  global advance enable; 0 freezes the stage (memory miss).
- `flush`  in  1  synchronous squash of all held entries.
- `in_valid`  in  1  upstream entry present.
- `in_ready`  out  1  stage can accept an entry.
- `in_data`  in  DATA_W  upstream data bundle.
- `in_ctrl`  in  CTRL_W  upstream control bundle.
- `out_valid`  out  1  stage output holds a valid entry.
- `out_ready`  in  1  downstream accepts the entry.
- `out_data`  out  DATA_W  registered data bundle.
- `out_ctrl`  out  CTRL_W  registered control bundle; 0 when `out_valid`=0.
- `skid_full`  out  1  skid entry occupied (always 0 when SKID=0).

## Operation
- Transfers:
  - Input transfer `ti` = `in_valid & in_ready & hit`.
  - Output transfer `to` = `out_valid & out_ready & hit`.
  - When `hit`=0, no state changes except flush.
- States:
  - EMPTY: main slot invalid.
  - FULL: main slot valid.
  - SKID: main and skid slots both valid. This state is reachable only when SKID=1.
- `in_ready`:
  - SKID=1: `in_ready` = !`skid_full` (registered).
  - SKID=0: `in_ready` = !`out_valid` | `out_ready`.
- Transitions (no flush):
  - EMPTY: `ti` → FULL, main ← in.
  - FULL:
    - `ti & to` → FULL, main ← in.
    - `to` only → EMPTY.
    - `ti` only → SKID (SKID=1), skid ← in. With SKID=0 this case cannot occur.
  - SKID: `to` → FULL, main ← skid. `ti` is impossible because `in_ready`=0.
- Flush:
  - Priority over every transfer.
  - Applies even when `hit`=0.
  - Next state EMPTY, `skid_full`=0, and `out_ctrl` and skid ctrl cleared to 0.
  - Data registers hold their values; they are don't-care while invalid.
  - An input offered in the flush cycle is dropped.
- Bubble rule: on any transition to EMPTY, `out_ctrl` is written to 0. This means a downstream stage that ignores `out_valid` still sees no `reg_write` or `mem_write`.
- Ordering: entries leave in arrival order; the skid entry is never bypassed.

## Timing
- Reset (async assert, falling-edge-synchronous release):
  - `out_valid`=0, `skid_full`=0.
  - `out_data`=0, `out_ctrl`=0, skid storage=0.
  - `in_ready`=1.
- Latency: one falling edge from `ti` to `out_valid`/`out_data` update.
- Throughput: one entry per cycle with `out_ready`=1 in both modes.
- SKID=1 timing:
  - `in_ready` drops on the edge where the skid loads.
  - `in_ready` rises on the edge where the skid drains to main.
  - No combinational path from `out_ready` to `in_ready`.
- `hit` low mid-handshake: values held, no transfer counted, handshake resumes when `hit` returns.
- Reset mid-operation discards all entries immediately.

## Structure
- Shared package `pipe_pkg`:
  - State enum (`PS_EMPTY`, `PS_FULL`, `PS_SKID`).
  - Default `CTRL_W`/`DATA_W` constants per pipeline boundary.
  - Control-field bit positions (`reg_dst`, `alu_src`, `mem_to_reg`, `reg_write`, `mem_read`, `mem_write`, `branch`, `jump`, `alu_op[2:0]`, `type[2:0]`).
- One sub-module: `pipe_stage_slot`, which stores valid, data and ctrl with load and clear inputs and zeroes ctrl on clear. It is instantiated as main and, under `generate` when SKID=1, as skid.

## Test plan
- Reset: hold `rst_n`=0 with `in_valid`=1, `in_ctrl`=14'h3FFF, and pulse `clk` → `out_valid`=0, `out_ctrl`=0, `in_ready`=1 throughout.
- Streaming: SKID=1, `out_ready`=1, `hit`=1, data 1..8 on consecutive edges → `out_data` 1..8 one edge later each, `skid_full` never set.
- Backpressure: `out_ready`=0 while sending A then B → A in main, B in skid, `in_ready`=0. Then `out_ready`=1 → A then B emerge in order, and `in_ready` returns to 1 after the B drain edge.
- Freeze: `hit`=0 for 3 cycles with `in_valid`=`out_ready`=1 → outputs constant, no entry lost or duplicated when `hit` returns to 1.
- Flush: stage in SKID state, `flush`=1 with `in_valid`=1 and `hit`=0 → next edge `out_valid`=0, `out_ctrl`=0, `skid_full`=0, offered entry dropped.
- SKID=0: `out_ready`=0 → `in_ready`=0 combinationally. Then `out_ready`=1 with new input → `in_ready`=1 in the same cycle, main replaced in one edge.
